// File: rtl/microcode_seq.sv
// Microcoded LED/PWM sequencer: 16-bit program words run through a FETCH/EXEC FSM.
// Supports WAIT (prescaled delay), JMP/DJNZ looping and HALT.
module microcode_seq #(
    parameter int COUNTER_BITS  = 4,
    parameter int PC_BITS       = 5,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    prog_we,
    input  logic [PC_BITS-1:0]      prog_addr,
    input  logic [15:0]             prog_data,
    output logic [11:0]             vec,
    output logic [COUNTER_BITS-1:0] duty1,
    output logic [COUNTER_BITS-1:0] duty2,
    output logic [PC_BITS-1:0]      pc,
    output logic                    halted
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, HALT} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             mem_q [2**PC_BITS];
    logic [15:0]             ir_q, ir_d;
    logic [11:0]             vec_q, vec_d;
    logic [11:0]             rem_q, rem_d;
    logic [COUNTER_BITS-1:0] d1_q, d1_d, d2_q, d2_d;
    logic [PC_BITS-1:0]      pc_q, pc_d, pc_inc, target;
    logic [7:0]              loop_q, loop_d;
    logic [2:0]              opcode;
    logic [12:0]             operand;
    logic                    tick;

    // Program memory is never reset; a same-cycle write is seen by the next fetch only.
    always_ff @(posedge clk) begin
        if (prog_we) mem_q[prog_addr] <= prog_data;
    end

    generate
        if (PRESCALE_BITS == 0) begin : g_nopresc
            assign tick = 1'b1;
        end else begin : g_presc
            logic [PRESCALE_BITS-1:0] presc_q;
            always_ff @(posedge clk) begin
                if (rst) presc_q <= '0;
                else     presc_q <= presc_q + 1'b1;
            end
            assign tick = &presc_q;
        end
    endgenerate

    assign opcode  = ir_q[15:13];
    assign operand = ir_q[12:0];
    assign pc_inc  = pc_q + 1'b1;
    assign target  = operand[PC_BITS-1:0];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        vec_d   = vec_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        pc_d    = pc_q;
        rem_d   = rem_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE:  if (run) state_d = FETCH;
            FETCH: begin
                if (!run) state_d = IDLE;
                else begin
                    ir_d    = mem_q[pc_q];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!run) state_d = IDLE;
                else begin
                    state_d = FETCH;
                    case (opcode)
                        3'b000: pc_d = pc_inc;
                        3'b001: begin
                            vec_d = operand[11:0];
                            pc_d  = pc_inc;
                        end
                        3'b010: begin
                            if (operand[12]) d2_d = operand[COUNTER_BITS-1:0];
                            else             d1_d = operand[COUNTER_BITS-1:0];
                            pc_d = pc_inc;
                        end
                        3'b011: begin
                            rem_d = operand[11:0];
                            if (operand[11:0] == 12'd0) pc_d = pc_inc;
                            else                        state_d = WAIT;
                        end
                        3'b100: pc_d = target;
                        3'b101: begin
                            loop_d = operand[7:0];
                            pc_d   = pc_inc;
                        end
                        3'b110: begin
                            if (loop_q != 8'd0) begin
                                loop_d = loop_q - 1'b1;
                                pc_d   = target;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        default: state_d = HALT;
                    endcase
                end
            end
            WAIT: begin
                // Leaving on the last tick lets the next FETCH follow immediately.
                if (!run) state_d = IDLE;
                else if (tick) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 12'd1) begin
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (!run) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            vec_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            pc_q    <= '0;
            rem_q   <= '0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            vec_q   <= vec_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            loop_q  <= loop_d;
        end
    end

    assign vec    = vec_q;
    assign duty1  = d1_q;
    assign duty2  = d2_q;
    assign pc     = pc_q;
    assign halted = (state_q == HALT);
endmodule

// File: tb/tb_microcode_seq.sv
// Bench for microcode_seq: vector table, directed corner sequences and random runs
// against an instruction-level reference model (two prescaler settings).
module tb_microcode_seq;
    logic        clk = 1'b0;
    logic        rst, run, prog_we;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [11:0] vecA, vecB;
    logic [3:0]  d1A, d2A, d1B, d2B;
    logic [4:0]  pcA, pcB;
    logic        hA, hB;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    microcode_seq #(.COUNTER_BITS(4), .PC_BITS(5), .PRESCALE_BITS(0)) dutA (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .vec(vecA), .duty1(d1A), .duty2(d2A), .pc(pcA), .halted(hA));
    microcode_seq #(.COUNTER_BITS(4), .PC_BITS(5), .PRESCALE_BITS(2)) dutB (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .vec(vecB), .duty1(d1B), .duty2(d2B), .pc(pcB), .halted(hB));

    // Reference model: "active" = program running, "exec_due" = fetched word pending,
    // wl = wait ticks still owed.
    typedef struct packed {
        logic [11:0] vec;
        logic [3:0]  d1, d2;
        logic [4:0]  pc;
        logic        halted, active, exec_due;
        logic [15:0] ir;
        logic [11:0] wl;
        logic [7:0]  loopc;
        logic [7:0]  presc;
    } mdl_t;

    mdl_t        mA, mB;
    logic [15:0] mem_m [32];

    function automatic mdl_t mstep(mdl_t m, int pb, logic r, logic rn);
        mdl_t        n;
        logic        tick;
        logic [12:0] opd;
        int          mask;
        n    = m;
        mask = (1 << pb) - 1;
        tick = (int'(m.presc) == mask);
        if (r) begin
            n = '0;
            return n;
        end
        n.presc = 8'((int'(m.presc) + 1) & mask);
        if (m.halted) begin
            if (!rn) begin n.halted = 1'b0; n.pc = 5'd0; n.active = 1'b0; end
        end else if (!m.active) begin
            if (rn) begin n.active = 1'b1; n.exec_due = 1'b0; n.wl = 12'd0; end
        end else if (!rn) begin
            n.active = 1'b0;
        end else if (m.wl != 12'd0) begin
            if (tick) begin
                n.wl = m.wl - 12'd1;
                if (n.wl == 12'd0) n.pc = m.pc + 5'd1;
            end
        end else if (!m.exec_due) begin
            n.ir       = mem_m[m.pc];
            n.exec_due = 1'b1;
        end else begin
            n.exec_due = 1'b0;
            opd        = m.ir[12:0];
            case (m.ir[15:13])
                3'd0: n.pc = m.pc + 5'd1;
                3'd1: begin n.vec = opd[11:0]; n.pc = m.pc + 5'd1; end
                3'd2: begin
                    if (opd[12]) n.d2 = opd[3:0];
                    else         n.d1 = opd[3:0];
                    n.pc = m.pc + 5'd1;
                end
                3'd3: begin
                    n.wl = opd[11:0];
                    if (opd[11:0] == 12'd0) n.pc = m.pc + 5'd1;
                end
                3'd4: n.pc = opd[4:0];
                3'd5: begin n.loopc = opd[7:0]; n.pc = m.pc + 5'd1; end
                3'd6: begin
                    if (m.loopc != 8'd0) begin n.loopc = m.loopc - 8'd1; n.pc = opd[4:0]; end
                    else n.pc = m.pc + 5'd1;
                end
                default: n.halted = 1'b1;
            endcase
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic rn, input logic we,
                       input logic [4:0] a, input logic [15:0] d);
        rst = r; run = rn; prog_we = we; prog_addr = a; prog_data = d;
        @(posedge clk);
        mA = mstep(mA, 0, r, rn);
        mB = mstep(mB, 2, r, rn);
        if (we) mem_m[a] = d;
        #1;
        chk("modelA", {vecA, d1A, d2A, pcA, hA}, {mA.vec, mA.d1, mA.d2, mA.pc, mA.halted});
        chk("modelB", {vecB, d1B, d2B, pcB, hB}, {mB.vec, mB.d1, mB.d2, mB.pc, mB.halted});
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 5'd0, 16'h0);
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) load(5'(i), 16'h0000);
    endtask

    function automatic logic [15:0] rword();
        logic [2:0]  op;
        logic [12:0] opd;
        op  = 3'($urandom_range(0, 7));
        opd = 13'($urandom);
        if (op == 3'd3) opd[11:0] = 12'($urandom_range(0, 6));
        return {op, opd};
    endfunction

    typedef struct {
        logic        r, rn;
        logic [11:0] v;
        logic [3:0]  d2;
        logic [4:0]  pc;
        logic        h;
    } tv_t;
    tv_t tv [11];

    initial begin
        int n, setv;
        logic [4:0] prev;
        for (int i = 0; i < 32; i++) mem_m[i] = 16'h0;
        mA = '0;
        mB = '0;

        // Run starts at row 1: the IDLE->FETCH edge, then 2 cycles per instruction.
        tv[0]  = '{1'b1, 1'b0, 12'h000, 4'h0, 5'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 12'h000, 4'h0, 5'd0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 12'h000, 4'h0, 5'd0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 12'hA5A, 4'h0, 5'd1, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 12'hA5A, 4'h0, 5'd1, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 12'hA5A, 4'h9, 5'd2, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 12'hA5A, 4'h9, 5'd2, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 12'hA5A, 4'h9, 5'd2, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 12'hA5A, 4'h9, 5'd2, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 12'hA5A, 4'h9, 5'd0, 1'b0};
        tv[10] = '{1'b0, 1'b0, 12'hA5A, 4'h9, 5'd0, 1'b0};

        clear_prog();
        load(5'd0, 16'h2A5A); load(5'd1, 16'h5009); load(5'd2, 16'hE000);
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].r, tv[i].rn, 1'b0, 5'd0, 16'h0);
            chk($sformatf("tv%0d_vec", i), vecA, tv[i].v);
            chk($sformatf("tv%0d_duty2", i), d2A, tv[i].d2);
            chk($sformatf("tv%0d_pc", i), pcA, tv[i].pc);
            chk($sformatf("tv%0d_halted", i), hA, tv[i].h);
        end

        // WAIT 3 then WAIT 0 latency
        clear_prog();
        load(5'd0, 16'h6003); load(5'd1, 16'h20F0); load(5'd2, 16'h6000);
        load(5'd3, 16'h200F); load(5'd4, 16'hE000);
        run_n(3);
        chk("wait3_pc", pcA, 0);
        n = 0;
        do begin run_n(1); n++; end while (vecA != 12'h0F0 && n < 20);
        chk("wait3_lat", n, 5);
        n = 0;
        do begin run_n(1); n++; end while (vecA != 12'h00F && n < 20);
        chk("wait0_lat", n, 4);
        chk("wait0_pc", pcA, 4);

        // LDC/DJNZ loop, then rerun without LDC to show the counter ended at 0
        clear_prog();
        load(5'd0, 16'hA002); load(5'd1, 16'h2001); load(5'd2, 16'hC001); load(5'd3, 16'hE000);
        n = 0; setv = 0; prev = pcA;
        do begin
            run_n(1); n++;
            if (prev == 5'd1 && pcA == 5'd2) setv++;
            prev = pcA;
        end while (!hA && n < 40);
        chk("djnz_cycles", n, 17);
        chk("djnz_setv", setv, 3);
        chk("djnz_pc", pcA, 3);
        cyc(1'b0, 1'b0, 1'b1, 5'd0, 16'h0000);
        chk("halt_exit_pc", pcA, 0);
        chk("halt_exit_h", hA, 0);
        n = 0; setv = 0; prev = pcA;
        do begin
            run_n(1); n++;
            if (prev == 5'd1 && pcA == 5'd2) setv++;
            prev = pcA;
        end while (!hA && n < 40);
        chk("loop0_cycles", n, 9);
        chk("loop0_setv", setv, 1);

        // JMP 31 / NOP wrap, then stop mid-instruction and resume
        clear_prog();
        load(5'd0, 16'h2111); load(5'd1, 16'h2222); load(5'd2, 16'h801F);
        run_n(3);
        chk("wrap_vec1", vecA, 12'h111);
        run_n(2);
        chk("wrap_vec2", vecA, 12'h222);
        run_n(2);
        chk("jmp31_pc", pcA, 31);
        run_n(2);
        chk("wrap_pc", pcA, 0);
        run_n(1);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
        chk("stop_pc", pcA, 0);
        chk("stop_vec", vecA, 12'h222);
        run_n(3);
        chk("resume_vec", vecA, 12'h111);
        chk("resume_pc", pcA, 1);

        // reset during WAIT and during HALT
        clear_prog();
        load(5'd0, 16'h2FFF); load(5'd1, 16'h4005); load(5'd2, 16'h6014); load(5'd3, 16'hE000);
        run_n(7);
        chk("pre_rst_state", {vecA, d1A, pcA}, {12'hFFF, 4'h5, 5'd2});
        run_n(3);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 16'h0);
        chk("rst_wait", {vecA, d1A, d2A, pcA, hA}, 0);
        n = 0;
        do begin run_n(1); n++; end while (!hA && n < 60);
        chk("rerun_halt_cycles", n, 29);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 16'h0);
        chk("rst_halt", {vecA, d1A, d2A, pcA, hA}, 0);
        run_n(3);
        chk("mem_kept_vec", vecA, 12'hFFF);
        run_n(2);
        chk("mem_kept_d1", d1A, 5);

        // write to the address being fetched
        clear_prog();
        load(5'd0, 16'h2111); load(5'd1, 16'h8000);
        run_n(1);
        cyc(1'b0, 1'b1, 1'b1, 5'd0, 16'h2222);
        run_n(1);
        chk("wr_fetch_old", vecA, 12'h111);
        run_n(4);
        chk("wr_fetch_new", vecA, 12'h222);

        // random programs and controls against the model
        clear_prog();
        for (int i = 0; i < 32; i++) load(5'(i), rword());
        for (int c = 0; c < 4000; c++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0,
                $urandom_range(0, 39) == 0, 5'($urandom_range(0, 31)), rword());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
